// File: rtl/lru_wb_cache_pkg.sv
// Shared definitions for the LRU write-back cache: controller states and
// the operation codes latched when a request is accepted.
package lru_wb_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVICT = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_INV = 2'd2
    } op_t;

endpackage

// File: rtl/lru_match_vector.sv
// Tag lookup for the recency stack.
//   tags/valid : stack contents, position 0 = MRU
//   req_tag    : address being looked up
//   hit_vec    : one-hot position of the matching line (tags are unique)
//   shift_down : bit i set when the hit sits at position >= i
//                (positions that move down one slot when the hit is promoted)
//   shift_up   : bit i set when the hit sits at position <= i
//                (positions that pull up one slot when the hit is removed)
//   miss       : no valid line matches
module lru_match_vector #(
    parameter int NUM_LINES = 4,
    parameter int TAG_WIDTH = 30
) (
    input  logic [NUM_LINES-1:0][TAG_WIDTH-1:0] tags,
    input  logic [NUM_LINES-1:0]                valid,
    input  logic [TAG_WIDTH-1:0]                req_tag,
    output logic [NUM_LINES-1:0]                hit_vec,
    output logic [NUM_LINES-1:0]                shift_down,
    output logic [NUM_LINES-1:0]                shift_up,
    output logic                                miss
);

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            hit_vec[i] = valid[i] && (tags[i] == req_tag);
        end
    end

    always_comb begin
        logic acc_dn;
        logic acc_up;
        shift_down = '0;
        shift_up   = '0;
        acc_dn     = 1'b0;
        acc_up     = 1'b0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            acc_dn        = acc_dn | hit_vec[i];
            shift_down[i] = acc_dn;
        end
        for (int i = 0; i < NUM_LINES; i++) begin
            acc_up      = acc_up | hit_vec[i];
            shift_up[i] = acc_up;
        end
    end

    assign miss = ~|hit_vec;

endmodule

// File: rtl/lru_wb_cache.sv
// Fully associative write-back cache with true-LRU replacement held as a
// recency-ordered shift stack (position 0 = MRU, NUM_LINES-1 = LRU).
//   clk, rst (async, active low)
//   req_tag, wr_data, RD_, WR_, invalidate : request, accepted while ready
//   ready, done, hit, rd_data              : completion
//   evict_valid/tag/data, evict_ready      : dirty victim writeback
//   fill_req/tag, fill_valid, fill_data    : refill on read miss
//
// state | meaning
// IDLE  | accepting requests; hits, write-misses and invalidates finish here
// EVICT | offering the dirty LRU line to memory
// FILL  | waiting for refill data of a read miss
module lru_wb_cache
    import lru_wb_cache_pkg::*;
#(
    parameter int NUM_LINES   = 4,
    parameter int TAG_WIDTH   = 30,
    parameter int VALUE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    input  logic [VALUE_WIDTH-1:0] wr_data,
    input  logic                   RD_,
    input  logic                   WR_,
    input  logic                   invalidate,
    output logic                   ready,
    output logic                   done,
    output logic                   hit,
    output logic [VALUE_WIDTH-1:0] rd_data,
    output logic                   evict_valid,
    output logic [TAG_WIDTH-1:0]   evict_tag,
    output logic [VALUE_WIDTH-1:0] evict_data,
    input  logic                   evict_ready,
    output logic                   fill_req,
    output logic [TAG_WIDTH-1:0]   fill_tag,
    input  logic                   fill_valid,
    input  logic [VALUE_WIDTH-1:0] fill_data
);

    localparam int LRU = NUM_LINES - 1;

    state_t state, state_n;
    op_t    op_q, op_n;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [VALUE_WIDTH-1:0] data_q;
    logic                   latch;

    logic [NUM_LINES-1:0]                  valid_q, valid_n, dirty_q, dirty_n;
    logic [NUM_LINES-1:0][TAG_WIDTH-1:0]   tags_q, tags_n;
    logic [NUM_LINES-1:0][VALUE_WIDTH-1:0] values_q, values_n;

    logic                   done_n, hit_n;
    logic [VALUE_WIDTH-1:0] rd_n;

    logic [NUM_LINES-1:0] hit_vec, shift_down, shift_up;
    logic                 miss;
    logic [VALUE_WIDTH-1:0] hit_value;
    logic                   hit_dirty;

    logic                   do_promote, do_inval, do_install;
    logic [TAG_WIDTH-1:0]   ins_tag;
    logic [VALUE_WIDTH-1:0] ins_value, promote_value;
    logic                   ins_dirty, promote_dirty;
    logic                   lru_dirty;

    lru_match_vector #(
        .NUM_LINES (NUM_LINES),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_match (
        .tags       (tags_q),
        .valid      (valid_q),
        .req_tag    (req_tag),
        .hit_vec    (hit_vec),
        .shift_down (shift_down),
        .shift_up   (shift_up),
        .miss       (miss)
    );

    always_comb begin
        hit_value = '0;
        hit_dirty = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (hit_vec[i]) begin
                hit_value = hit_value | values_q[i];
                hit_dirty = hit_dirty | dirty_q[i];
            end
        end
    end

    assign lru_dirty   = valid_q[LRU] & dirty_q[LRU];
    assign ready       = (state == ST_IDLE);
    assign evict_valid = (state == ST_EVICT);
    assign evict_tag   = evict_valid ? tags_q[LRU]   : '0;
    assign evict_data  = evict_valid ? values_q[LRU] : '0;
    assign fill_req    = (state == ST_FILL);
    assign fill_tag    = fill_req ? tag_q : '0;

    always_comb begin
        state_n       = state;
        op_n          = OP_RD;
        latch         = 1'b0;
        done_n        = 1'b0;
        hit_n         = 1'b0;
        rd_n          = rd_data;
        do_promote    = 1'b0;
        do_inval      = 1'b0;
        do_install    = 1'b0;
        ins_tag       = tag_q;
        ins_value     = data_q;
        ins_dirty     = 1'b1;
        promote_value = hit_value;
        promote_dirty = hit_dirty;
        valid_n       = valid_q;
        dirty_n       = dirty_q;
        tags_n        = tags_q;
        values_n      = values_q;

        case (state)
            ST_IDLE: begin
                if (invalidate) begin
                    latch    = 1'b1;
                    op_n     = OP_INV;
                    done_n   = 1'b1;
                    hit_n    = ~miss;
                    do_inval = ~miss;
                end else if (!WR_) begin
                    latch = 1'b1;
                    op_n  = OP_WR;
                    if (!miss) begin
                        do_promote    = 1'b1;
                        promote_value = wr_data;
                        promote_dirty = 1'b1;
                        done_n        = 1'b1;
                        hit_n         = 1'b1;
                    end else if (lru_dirty) begin
                        state_n = ST_EVICT;
                    end else begin
                        do_install = 1'b1;
                        ins_tag    = req_tag;
                        ins_value  = wr_data;
                        done_n     = 1'b1;
                    end
                end else if (!RD_) begin
                    latch = 1'b1;
                    if (!miss) begin
                        do_promote = 1'b1;
                        rd_n       = hit_value;
                        done_n     = 1'b1;
                        hit_n      = 1'b1;
                    end else if (lru_dirty) begin
                        state_n = ST_EVICT;
                    end else begin
                        state_n = ST_FILL;
                    end
                end
            end
            ST_EVICT: begin
                if (evict_ready) begin
                    if (op_q == OP_WR) begin
                        do_install = 1'b1;
                        done_n     = 1'b1;
                        state_n    = ST_IDLE;
                    end else begin
                        state_n = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (fill_valid) begin
                    do_install = 1'b1;
                    ins_value  = fill_data;
                    ins_dirty  = 1'b0;
                    rd_n       = fill_data;
                    done_n     = 1'b1;
                    state_n    = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Hit promoted to MRU; everything above it slides down one slot.
        if (do_promote) begin
            for (int i = 1; i < NUM_LINES; i++) begin
                if (shift_down[i]) begin
                    valid_n[i]  = valid_q[i-1];
                    dirty_n[i]  = dirty_q[i-1];
                    tags_n[i]   = tags_q[i-1];
                    values_n[i] = values_q[i-1];
                end
            end
            if (shift_down[0]) begin
                valid_n[0]  = 1'b1;
                dirty_n[0]  = promote_dirty;
                tags_n[0]   = req_tag;
                values_n[0] = promote_value;
            end
        end

        // Removed line closes the gap so valid lines stay contiguous from 0.
        if (do_inval) begin
            for (int i = 0; i < LRU; i++) begin
                if (shift_up[i]) begin
                    valid_n[i]  = valid_q[i+1];
                    dirty_n[i]  = dirty_q[i+1];
                    tags_n[i]   = tags_q[i+1];
                    values_n[i] = values_q[i+1];
                end
            end
            if (shift_up[LRU]) begin
                valid_n[LRU]  = 1'b0;
                dirty_n[LRU]  = 1'b0;
                tags_n[LRU]   = '0;
                values_n[LRU] = '0;
            end
        end

        // Miss: whole stack slides down, the LRU line falls off the end.
        if (do_install) begin
            for (int i = 1; i < NUM_LINES; i++) begin
                valid_n[i]  = valid_q[i-1];
                dirty_n[i]  = dirty_q[i-1];
                tags_n[i]   = tags_q[i-1];
                values_n[i] = values_q[i-1];
            end
            valid_n[0]  = 1'b1;
            dirty_n[0]  = ins_dirty;
            tags_n[0]   = ins_tag;
            values_n[0] = ins_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_RD;
            tag_q    <= '0;
            data_q   <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            tags_q   <= '0;
            values_q <= '0;
            done     <= 1'b0;
            hit      <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_n;
            valid_q  <= valid_n;
            dirty_q  <= dirty_n;
            tags_q   <= tags_n;
            values_q <= values_n;
            done     <= done_n;
            hit      <= hit_n;
            rd_data  <= rd_n;
            if (latch) begin
                op_q   <= op_n;
                tag_q  <= req_tag;
                data_q <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_lru_wb_cache.sv
module tb_lru_wb_cache;

    localparam int TW = 30;
    localparam int VW = 32;
    localparam logic [1:0] OPR = 2'd0;
    localparam logic [1:0] OPW = 2'd1;
    localparam logic [1:0] OPI = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] req_tag;
    logic [VW-1:0] wr_data;
    logic          rd_l, wr_l, invalidate;
    logic          ready, done, hit;
    logic [VW-1:0] rd_data;
    logic          evict_valid;
    logic [TW-1:0] evict_tag;
    logic [VW-1:0] evict_data;
    logic          evict_ready;
    logic          fill_req;
    logic [TW-1:0] fill_tag;
    logic          fill_valid;
    logic [VW-1:0] fill_data;

    always #5 clk = ~clk;

    lru_wb_cache #(.NUM_LINES(4), .TAG_WIDTH(TW), .VALUE_WIDTH(VW)) dut (
        .clk(clk), .rst(rst), .req_tag(req_tag), .wr_data(wr_data),
        .RD_(rd_l), .WR_(wr_l), .invalidate(invalidate),
        .ready(ready), .done(done), .hit(hit), .rd_data(rd_data),
        .evict_valid(evict_valid), .evict_tag(evict_tag), .evict_data(evict_data),
        .evict_ready(evict_ready), .fill_req(fill_req), .fill_tag(fill_tag),
        .fill_valid(fill_valid), .fill_data(fill_data)
    );

    typedef struct {
        logic          hit;
        logic          is_rd;
        logic [VW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse consumes one expected completion.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done got done=1 expected no pending request");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_hit", hit, e.hit);
                if (e.is_rd) check("sb_rd_data", rd_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            cyc();
            n++;
        end
        check("ready_wait", ready, 1);
    endtask

    task automatic req(input logic [1:0] op, input logic [TW-1:0] t, input logic [VW-1:0] d,
                       input logic eh, input logic erd, input logic [VW-1:0] ed);
        wait_ready();
        sb.push_back('{eh, erd, ed});
        req_tag    = t;
        wr_data    = d;
        invalidate = (op == OPI);
        wr_l       = !(op == OPW);
        rd_l       = !(op == OPR);
        cyc();
        rd_l       = 1'b1;
        wr_l       = 1'b1;
        invalidate = 1'b0;
    endtask

    task automatic do_fill(input logic [TW-1:0] t, input logic [VW-1:0] d, input int dly);
        check("fill_req", fill_req, 1);
        check("fill_tag", fill_tag, t);
        check("fill_ready_low", ready, 0);
        repeat (dly) cyc();
        fill_data  = d;
        fill_valid = 1'b1;
        cyc();
        fill_valid = 1'b0;
        check("fill_done", done, 1);
    endtask

    // Victim handshake; a read strobe is held during the wait and must be ignored.
    task automatic evict_hs(input logic [TW-1:0] t, input logic [VW-1:0] d, input int hold);
        check("evict_valid", evict_valid, 1);
        check("evict_tag", evict_tag, t);
        check("evict_data", evict_data, d);
        check("evict_ready_low", ready, 0);
        req_tag = 30'd5;
        rd_l    = 1'b0;
        repeat (hold) begin
            cyc();
            check("evict_hold_valid", evict_valid, 1);
            check("evict_hold_tag", evict_tag, t);
        end
        rd_l        = 1'b1;
        evict_ready = 1'b1;
        cyc();
        evict_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rd_l = 1'b1; wr_l = 1'b1; invalidate = 1'b0;
        req_tag = '0; wr_data = '0; evict_ready = 1'b0;
        fill_valid = 1'b0; fill_data = '0;
        #3;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_hit", hit, 0);
        check("rst_evict_valid", evict_valid, 0);
        check("rst_fill_req", fill_req, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_evict_tag", evict_tag, 0);
        check("rst_evict_data", evict_data, 0);
        check("rst_fill_tag", fill_tag, 0);
        cyc();
        rst = 1'b1;

        // Read miss with refill, then hit on the same tag.
        req(OPR, 30'd5, 32'd0, 1'b0, 1'b1, 32'hA5);
        do_fill(30'd5, 32'hA5, 2);
        req(OPR, 30'd5, 32'd0, 1'b1, 1'b1, 32'hA5);
        check("hit_latency_done", done, 1);
        check("hit_ready_high", ready, 1);

        // Fill with writes; tag 5 (clean LRU) is dropped silently by tag 4.
        for (int t = 1; t <= 4; t++) begin
            req(OPW, TW'(t), 32'h100 + 32'(t), 1'b0, 1'b0, 32'd0);
            check("wr_miss_done", done, 1);
            check("wr_miss_no_evict", evict_valid, 0);
        end
        check("rd_data_hold", rd_data, 32'hA5);
        req(OPR, 30'd1, 32'd0, 1'b1, 1'b1, 32'h101);
        // Stack 1,4,3,2 -> writing 6 evicts dirty 2.
        req(OPW, 30'd6, 32'h106, 1'b0, 1'b0, 32'd0);
        evict_hs(30'd2, 32'h102, 3);
        check("evict_wr_done", done, 1);

        // Invalidate dirty 3: no writeback, later read misses.
        req(OPI, 30'd3, 32'd0, 1'b1, 1'b0, 32'd0);
        check("inv_no_evict", evict_valid, 0);
        wait_ready();
        sb.push_back('{1'b0, 1'b1, 32'h33});
        fill_data = 32'h33; fill_valid = 1'b1;
        req_tag = 30'd3; rd_l = 1'b0;
        cyc();
        rd_l = 1'b1;
        check("refill_no_evict", evict_valid, 0);
        check("refill_req", fill_req, 1);
        check("refill_tag", fill_tag, 30'd3);
        cyc();
        fill_valid = 1'b0;
        check("fill_same_cycle_done", done, 1);
        req(OPI, 30'd9, 32'd0, 1'b0, 1'b0, 32'd0);

        // All three strobes together: only the invalidate of 4 happens.
        wait_ready();
        sb.push_back('{1'b1, 1'b0, 32'd0});
        req_tag = 30'd4; wr_data = 32'hDEAD;
        rd_l = 1'b0; wr_l = 1'b0; invalidate = 1'b1;
        cyc();
        rd_l = 1'b1; wr_l = 1'b1; invalidate = 1'b0;
        req(OPR, 30'd4, 32'd0, 1'b0, 1'b1, 32'h44);
        do_fill(30'd4, 32'h44, 1);

        // Stack 4,3,6,1 -> dirty victims 1 then 6.
        req(OPW, 30'd2, 32'h202, 1'b0, 1'b0, 32'd0);
        evict_hs(30'd1, 32'h101, 0);
        check("evict2_done", done, 1);
        req(OPW, 30'd1, 32'h101, 1'b0, 1'b0, 32'd0);
        evict_hs(30'd6, 32'h106, 1);
        req(OPW, 30'd4, 32'h404, 1'b1, 1'b0, 32'd0);
        req(OPW, 30'd3, 32'h303, 1'b1, 1'b0, 32'd0);

        // Eight back-to-back alternating hits; order afterwards 2,1,3,4.
        wait_ready();
        for (int k = 0; k < 8; k++) begin
            logic [TW-1:0] t;
            t = (k % 2 == 0) ? 30'd1 : 30'd2;
            sb.push_back('{1'b1, 1'b1, (k % 2 == 0) ? 32'h101 : 32'h202});
            req_tag = t;
            rd_l = 1'b0;
            cyc();
            check("stream_done", done, 1);
        end
        rd_l = 1'b1;
        req(OPW, 30'd7, 32'h707, 1'b0, 1'b0, 32'd0);
        evict_hs(30'd4, 32'h404, 0);
        req(OPW, 30'd8, 32'h808, 1'b0, 1'b0, 32'd0);
        evict_hs(30'd3, 32'h303, 0);

        // Reset in the middle of an eviction.
        req(OPW, 30'd9, 32'h909, 1'b0, 1'b0, 32'd0);
        check("pre_rst_evict_valid", evict_valid, 1);
        check("pre_rst_evict_tag", evict_tag, 30'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_evict_valid", evict_valid, 0);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_fill_req", fill_req, 0);
        check("mid_rst_done", done, 0);
        sb.delete();
        cyc();
        rst = 1'b1;
        req(OPR, 30'd8, 32'd0, 1'b0, 1'b1, 32'h88);
        do_fill(30'd8, 32'h88, 0);
        req(OPR, 30'd7, 32'd0, 1'b0, 1'b1, 32'h77);
        do_fill(30'd7, 32'h77, 1);

        repeat (3) cyc();
        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lru_wb_cache.md
# lru_wb_cache

Parametrised, write-back, fully associative cache with true-LRU replacement, kept as a recency-ordered shift stack (position 0 = MRU, position NUM_LINES-1 = LRU). Sits between the IF/MEM stage and the next memory level. Adds dirty-victim eviction, refill from memory and a ready/done handshake, all of which the 4-line hit/miss-only cache lacks.

## Interface

- NUM_LINES, 4, number of lines; must be ≥2.
- TAG_WIDTH, 30, tag (word-address) width.
- VALUE_WIDTH, 32, data word width.

Ports:

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_tag  in  TAG_WIDTH  request address.
- wr_data  in  VALUE_WIDTH  write data.
- RD_  in  1  read strobe, active low.
- WR_  in  1  write strobe, active low.
- invalidate  in  1  drop the entry matching req_tag, with no writeback.
- ready  out  1  request accepted this cycle when high.
- done  out  1  one-cycle pulse: request complete.
- hit  out  1  qualified by done: request hit.
- rd_data  out  VALUE_WIDTH  read result, valid with done on a read.
- evict_valid  out  1  victim offered to memory.
- evict_tag  out  TAG_WIDTH  victim tag.
- evict_data  out  VALUE_WIDTH  victim data.
- evict_ready  in  1  memory accepts the victim.
- fill_req  out  1  refill request.
- fill_tag  out  TAG_WIDTH  refill address.
- fill_valid  in  1  refill data present.
- fill_data  in  VALUE_WIDTH  refill word.

## Operation

- **States:**
  - IDLE: ready=1.
  - EVICT: ready=0.
  - FILL: ready=0.
  - Tag, data and operation are latched when a request is accepted.
- **Acceptance and priority** (IDLE only): invalidate > write (WR_=0) > read (RD_=0).
- **Stack invariant:** valid entries are contiguous from position 0.
- **Read hit:**
  - Entry moves to position 0.
  - Positions 0..hit-1 shift down by one.
  - rd_data is loaded.
  - done=1, hit=1.
- **Write hit:** same reorder as a read hit; value is replaced and dirty is set.
- **Miss:** all entries shift down one position and the new entry enters at position 0.
  - If the LRU entry is valid and dirty, go to EVICT first.
  - EVICT: evict_valid is held with the LRU tag/data until evict_ready. Then go to FILL (read) or install (write).
- **Read miss:** FILL holds fill_req/fill_tag until fill_valid. Install fill_data clean, rd_data=fill_data, done=1, hit=0, return to IDLE.
- **Write miss:** write-allocate with no fill. Install wr_data dirty, done=1, hit=0.
- **Invalidate hit:**
  - Entries below the match shift up.
  - The LRU slot becomes invalid.
  - Dirty data is discarded.
  - done=1, hit=1.
- **Invalidate miss:** done=1, hit=0, no state change.
- Clean or invalid victims are overwritten silently.

## Timing

- **Reset** (asynchronous, any state, including mid-EVICT/FILL): state=IDLE, every valid/dirty/tag/value=0, and the request is abandoned.
  - ready=1; done, hit, evict_valid, fill_req=0.
  - rd_data, evict_tag, evict_data, fill_tag=0.
- **Hit latency:** accept at edge N, done high in cycle N+1, ready stays high (back-to-back hits every cycle).
- **Clean miss, write:** done at N+1.
- **Clean miss, read:** fill_req high from N+1. done on the cycle after fill_valid is sampled.
- **Dirty miss:** evict_valid from N+1. The next step begins the cycle after evict_valid&evict_ready.
- **Handshake rules:**
  - evict_*/fill_tag are stable while their valid/req signal is high.
  - fill_valid and evict_ready are ignored outside FILL and EVICT respectively.
  - fill_valid in the same cycle as entry to FILL is legal.
- **Holding:** rd_data holds until the next read completion; done is never high for two consecutive cycles on a single request.
- **Single line:** at most one entry per tag; a miss never duplicates a tag.

## Structure

- **Shared header:** state encodings (IDLE=0, EVICT=1, FILL=2) and operation codes (RD, WR, INV).
- **Sub-module lru_match_vector:** per-line compare (tag==req_tag & valid), one-hot hit index, prefix-OR shift-enable vector and a miss flag, all parametrised by NUM_LINES/TAG_WIDTH.
- **Top level:** the FSM, the storage arrays and the per-position next-value muxes.

## Test plan

- After reset, read tag 5 → miss, fill_req with fill_tag=5. fill_valid with data 0xA5 → done, hit=0, rd_data=0xA5. Re-read tag 5 → hit, data 0xA5 at N+1.
- NUM_LINES=4: write tags 1,2,3,4 (miss, no fill), read tag 1, write tag 6 → evict_valid with tag 2 and its data. Hold evict_ready low 3 cycles, then the cycle after evict_ready=1 → done, hit=0.
- Invalidate tag 3 on a dirty line → no evict. A following read of 3 misses and fills. Invalidate of an absent tag → hit=0, stack unchanged.
- RD_=0, WR_=0 and invalidate=1 in one cycle → only the invalidate is performed. Requests asserted while ready=0 are ignored.
- Assert rst mid-EVICT → evict_valid=0, ready=1 immediately, and every later read misses.
- Stream of 8 alternating hits on tags 1/2 → done every cycle. LRU order is checked by a following eviction of the expected tag.
